uart_tx: RTL

Serial UART transmitter that sits directly downstream of the pipeline debug unit. It accepts one byte plus a level-held request from the debug unit, serialises it LSB-first as 8N1 (optionally 8E1) on the TX line, and returns a one-cycle done pulse that the debug unit uses to advance to the next byte. It contains its own bit-period counter; there is no external baud tick.

---
 rtl/uart_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first 8N1 framing with an internal bit-period counter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits (8E1).
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_done,
    output logic                 o_busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shifted;
    logic                 rearm;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    assign shifted = shift_reg >> 1;

    // o_tx is registered, so each transition loads the level of the bit that starts next cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rearm     <= 1'b1;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
            o_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    // A request still held after done must be dropped before it can re-arm.
                    if (!i_tx_start) begin
                        rearm <= 1'b1;
                    end else if (rearm) begin
                        shift_reg <= i_tx_data;
                        cnt       <= '0;
                        rearm     <= 1'b0;
                        state     <= START;
                        o_tx      <= 1'b0;
                        o_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity    <= ^i_tx_data;
`endif
                    end
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        o_tx    <= shift_reg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= shifted;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            o_tx  <= parity;
`else
                            state <= STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            o_tx    <= shifted[0];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        o_tx      <= 1'b1;
                        o_tx_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
